// File: rtl/vote_tally_arbiter_if.sv
// Booth/readout bus of the vote tally arbiter: vote requests and grants,
// session control pulses and result readout.
interface vote_tally_arbiter_if #(
    parameter int N_BOOTH = 4,
    parameter int N_CAND  = 4,
    parameter int CAND_W  = 2
);
    logic                        open_poll;
    logic                        close_poll;
    logic                        clear;
    logic [N_BOOTH-1:0]          req;
    logic [N_BOOTH*CAND_W-1:0]   cand_sel;
    logic [N_BOOTH-1:0]          grant;
    logic [CAND_W-1:0]           rd_cand;
    logic [9:0]                  tally;
    logic [11:0]                 total;
    logic [1:0]                  state;
    logic [N_CAND-1:0]           sat;

    modport master (
        output open_poll, close_poll, clear, req, cand_sel, rd_cand,
        input  grant, tally, total, state, sat
    );

    modport slave (
        input  open_poll, close_poll, clear, req, cand_sel, rd_cand,
        output grant, tally, total, state, sat
    );
endinterface

// File: rtl/vote_tally_arbiter.sv
// Polling-session controller: round-robin arbitration of booth votes into a
// shared bank of saturating per-candidate tallies, gated by a session FSM.
module vote_tally_arbiter #(
    parameter int N_BOOTH   = 4,
    parameter int N_CAND    = 4,
    parameter int CAND_W    = 2,
    parameter int MAX_COUNT = 999
) (
    input logic                  clk,
    input logic                  reset,
    vote_tally_arbiter_if.slave  bus
);
    localparam int         PTR_W = (N_BOOTH > 1) ? $clog2(N_BOOTH) : 1;
    localparam logic [9:0] MAX_C = 10'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OPEN   = 2'b01,
        CLOSED = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [N_BOOTH-1:0]   grant_q, grant_d;
    logic [N_BOOTH-1:0]   elig;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     idx, win_idx;
    logic                 win_found;
    logic                 vote;
    logic [CAND_W-1:0]    booth_cand [N_BOOTH];
    logic [CAND_W-1:0]    win_cand;
    logic [9:0]           count_q [N_CAND];
    logic [9:0]           count_d [N_CAND];
    logic [11:0]          total_q, total_d;
    logic [N_CAND-1:0]    sat_q, sat_d;
    logic [9:0]           tally_q, tally_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.open_poll)  state_d = OPEN;
            OPEN:    if (bus.close_poll) state_d = CLOSED;
            CLOSED:  if (bus.clear)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // grant_q doubles as the last-grant mask: a just-granted booth sits out one edge.
    always_comb begin
        for (int unsigned b = 0; b < N_BOOTH; b++) begin
            booth_cand[b] = bus.cand_sel[b*CAND_W +: CAND_W];
        end
        elig      = bus.req & ~grant_q;
        win_found = 1'b0;
        win_idx   = ptr_q;
        idx       = '0;
        for (int unsigned i = 1; i <= N_BOOTH; i++) begin
            idx = PTR_W'((32'(ptr_q) + i) % N_BOOTH);
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        vote     = (state_q == OPEN) && !bus.close_poll && win_found;
        win_cand = booth_cand[win_idx];
    end

    always_comb begin
        grant_d = '0;
        ptr_d   = ptr_q;
        count_d = count_q;
        total_d = total_q;
        sat_d   = sat_q;
        tally_d = (int'(bus.rd_cand) < N_CAND) ? count_q[bus.rd_cand] : '0;
        if (vote) begin
            grant_d[win_idx] = 1'b1;
            ptr_d            = win_idx;
            if (int'(win_cand) < N_CAND) begin
                if (count_q[win_cand] == MAX_C) begin
                    sat_d[win_cand] = 1'b1;
                end else begin
                    count_d[win_cand] = count_q[win_cand] + 10'd1;
                    total_d           = total_q + 12'd1;
                end
            end
        end
        if (state_q == CLOSED && bus.clear) begin
            for (int unsigned c = 0; c < N_CAND; c++) begin
                count_d[c] = '0;
            end
            total_d = '0;
            sat_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_W'(N_BOOTH - 1);
            for (int unsigned c = 0; c < N_CAND; c++) begin
                count_q[c] <= '0;
            end
            total_q <= '0;
            sat_q   <= '0;
            tally_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            total_q <= total_d;
            sat_q   <= sat_d;
            tally_q <= tally_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.state = state_q;
    assign bus.tally = tally_q;
    assign bus.total = total_q;
    assign bus.sat   = sat_q;
endmodule

// File: tb/tb_vote_tally_arbiter.sv
// Directed bench for vote_tally_arbiter: session flow, round-robin rotation,
// single-booth pacing, saturation and asynchronous reset.
module tb_vote_tally_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;

    vote_tally_arbiter_if #(.N_BOOTH(4), .N_CAND(4), .CAND_W(2)) bus ();

    vote_tally_arbiter #(
        .N_BOOTH(4), .N_CAND(4), .CAND_W(2), .MAX_COUNT(999)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.open_poll  = 1'b0;
        bus.close_poll = 1'b0;
        bus.clear      = 1'b0;
        bus.req        = '0;
        bus.cand_sel   = '0;
        bus.rd_cand    = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic pulse_open();
        bus.open_poll = 1'b1;
        tick();
        bus.open_poll = 1'b0;
    endtask

    task automatic read_tally(input logic [1:0] c, input int unsigned exp, input string tag);
        bus.rd_cand = c;
        tick();
        check(tag, bus.tally, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check("rst_state", bus.state, 0);
        check("rst_grant", bus.grant, 0);
        check("rst_total", bus.total, 0);
        check("rst_tally", bus.tally, 0);
        check("rst_sat",   bus.sat,   0);

        // single vote from booth 0 for candidate 2
        pulse_open();
        check("t1_open", bus.state, 1);
        bus.cand_sel = 8'h02;
        bus.req      = 4'b0001;
        tick();
        check("t1_grant", bus.grant, 4'b0001);
        check("t1_total", bus.total, 1);
        bus.req = '0;
        tick();
        check("t1_grant_drop", bus.grant, 0);
        bus.close_poll = 1'b1;
        tick();
        bus.close_poll = 1'b0;
        check("t1_closed", bus.state, 2);
        read_tally(2'd2, 1, "t1_tally2");
        check("t1_total_hold", bus.total, 1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("t1_clr_state", bus.state, 0);
        check("t1_clr_total", bus.total, 0);
        read_tally(2'd2, 0, "t1_clr_tally2");

        // all booths request continuously, candidate = booth index
        do_reset();
        bus.req      = 4'b1111;
        bus.cand_sel = 8'b11_10_01_00;
        pulse_open();
        check("t2_open", bus.state, 1);
        check("t2_open_edge_grant", bus.grant, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t2_rotate", bus.grant, 32'(1) << (k % 4));
        end
        check("t2_total", bus.total, 8);
        bus.close_poll = 1'b1;
        bus.open_poll  = 1'b1;
        tick();
        bus.close_poll = 1'b0;
        bus.open_poll  = 1'b0;
        check("t2_close_wins", bus.state, 2);
        check("t2_close_edge_grant", bus.grant, 0);
        tick();
        check("t2_closed_grant", bus.grant, 0);
        check("t2_closed_total", bus.total, 8);
        bus.req = '0;
        for (int c = 0; c < 4; c++) begin
            read_tally(2'(c), 2, "t2_tally");
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("t2_clr_state", bus.state, 0);
        check("t2_clr_total", bus.total, 0);
        check("t2_clr_sat",   bus.sat,   0);
        read_tally(2'd3, 0, "t2_clr_tally3");

        // booth 1 alone, re-raising req after each grant
        do_reset();
        pulse_open();
        bus.cand_sel = 8'b00_00_01_00;
        bus.clear    = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("t3_clear_ignored", bus.state, 1);
        for (int v = 0; v < 10; v++) begin
            bus.req = 4'b0010;
            tick();
            check("t3_grant", bus.grant, 4'b0010);
            bus.req = '0;
            tick();
            check("t3_gap", bus.grant, 0);
        end
        check("t3_total", bus.total, 10);
        read_tally(2'd1, 10, "t3_tally1");
        bus.req = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_held", bus.grant, (k % 2 == 0) ? 4'b0010 : 4'b0000);
        end
        bus.req = '0;
        check("t3_held_total", bus.total, 12);
        read_tally(2'd1, 12, "t3_held_tally1");

        // saturation of candidate 3 via booths 0 and 2
        do_reset();
        pulse_open();
        bus.cand_sel = 8'hFF;
        bus.req      = 4'b0101;
        repeat (999) tick();
        bus.req = '0;
        tick();
        check("t4_idle_grant", bus.grant, 0);
        check("t4_total_999", bus.total, 999);
        check("t4_sat_clear", bus.sat, 0);
        read_tally(2'd3, 999, "t4_tally_999");
        bus.req = 4'b0101;
        tick();
        check("t4_sat_grant_a", bus.grant, 4'b0100);
        tick();
        check("t4_sat_grant_b", bus.grant, 4'b0001);
        bus.req = '0;
        tick();
        check("t4_sat_flag", bus.sat, 4'b1000);
        check("t4_total_hold", bus.total, 999);
        read_tally(2'd3, 999, "t4_tally_hold");

        // asynchronous reset mid-session
        bus.req = 4'b0001;
        tick();
        check("t5_pre_grant", bus.grant, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        check("t5_grant", bus.grant, 0);
        check("t5_state", bus.state, 0);
        check("t5_total", bus.total, 0);
        check("t5_tally", bus.tally, 0);
        check("t5_sat",   bus.sat,   0);
        bus.req = '0;
        tick();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
